// File: rtl/operand_queue.sv
// Operand queue: buffers VRF read words and frames them into per-instruction operand streams.
// Define OPQUEUE_BYPASS_EN to let a word skip the empty data FIFO straight to the consumer.
module operand_queue #(
  parameter int Depth         = 4,
  parameter int CmdDepth      = 2,
  parameter int VrfWordWidthB = 8,
  parameter int VlenWidth     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [VlenWidth-1:0]         cmd_vl_i,
  input  logic                         op_valid_i,
  output logic                         op_ready_o,
  input  logic [8*VrfWordWidthB-1:0]   operand_i,
  output logic                         opnd_valid_o,
  input  logic                         opnd_ready_i,
  output logic [8*VrfWordWidthB-1:0]   opnd_o,
  output logic [VrfWordWidthB-1:0]     opnd_strb_o,
  output logic                         opnd_last_o,
  output logic [$clog2(Depth):0]       occupancy_o
);

  localparam int W   = VrfWordWidthB;
  localparam int DAW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int DCW = $clog2(Depth) + 1;
  localparam int CAW = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
  localparam int CCW = $clog2(CmdDepth) + 1;
  localparam logic [VlenWidth-1:0] WORD_BYTES = VlenWidth'(W);

  // state  | meaning
  // IDLE   | no instruction framed; waiting for a command
  // ACTIVE | streaming the current instruction, remain_q bytes still owed
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [VlenWidth-1:0] remain_q, remain_d;

  logic [8*W-1:0] data_mem [Depth];
  logic [DAW-1:0] data_wr_q, data_rd_q;
  logic [DCW-1:0] data_cnt_q;
  logic           data_empty, data_full, data_push, data_pop;

  logic [VlenWidth-1:0] cmd_mem [CmdDepth];
  logic [CAW-1:0]       cmd_wr_q, cmd_rd_q;
  logic [CCW-1:0]       cmd_cnt_q;
  logic                 cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic [VlenWidth-1:0] cmd_head;

  logic           bypass, byp_take, out_valid, hs, is_last;
  logic [W-1:0]   strb_calc;

  assign data_empty  = (data_cnt_q == '0);
  assign data_full   = (data_cnt_q == DCW'(Depth));
  assign op_ready_o  = !data_full;
  assign occupancy_o = data_cnt_q;

  assign cmd_empty   = (cmd_cnt_q == '0);
  assign cmd_full    = (cmd_cnt_q == CCW'(CmdDepth));
  assign cmd_ready_o = !cmd_full;
  assign cmd_push    = cmd_valid_i && !cmd_full;
  assign cmd_head    = cmd_mem[cmd_rd_q];

`ifdef OPQUEUE_BYPASS_EN
  assign bypass = (state_q == ACTIVE) && data_empty && op_valid_i;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid    = (state_q == ACTIVE) && (!data_empty || bypass);
  assign opnd_valid_o = out_valid;
  assign hs           = out_valid && opnd_ready_i;
  // A bypassed word that is consumed immediately never occupies a FIFO slot.
  assign byp_take     = bypass && opnd_ready_i;
  assign data_push    = op_valid_i && !data_full && !byp_take;
  assign data_pop     = hs && !bypass;
  assign is_last      = (remain_q <= WORD_BYTES);

  always_comb begin
    strb_calc = '0;
    for (int b = 0; b < W; b++)
      strb_calc[b] = (remain_q >= WORD_BYTES) || (VlenWidth'(b) < remain_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_wr_q  <= '0;
      data_rd_q  <= '0;
      data_cnt_q <= '0;
    end else begin
      if (data_push) data_wr_q <= (data_wr_q == DAW'(Depth - 1)) ? '0 : data_wr_q + 1'b1;
      if (data_pop)  data_rd_q <= (data_rd_q == DAW'(Depth - 1)) ? '0 : data_rd_q + 1'b1;
      if (data_push && !data_pop)      data_cnt_q <= data_cnt_q + 1'b1;
      else if (!data_push && data_pop) data_cnt_q <= data_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_push) data_mem[data_wr_q] <= operand_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      if (cmd_push) cmd_wr_q <= (cmd_wr_q == CAW'(CmdDepth - 1)) ? '0 : cmd_wr_q + 1'b1;
      if (cmd_pop)  cmd_rd_q <= (cmd_rd_q == CAW'(CmdDepth - 1)) ? '0 : cmd_rd_q + 1'b1;
      if (cmd_push && !cmd_pop)      cmd_cnt_q <= cmd_cnt_q + 1'b1;
      else if (!cmd_push && cmd_pop) cmd_cnt_q <= cmd_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_push) cmd_mem[cmd_wr_q] <= cmd_vl_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    cmd_pop     = 1'b0;
    opnd_o      = '0;
    opnd_strb_o = '0;
    opnd_last_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          if (cmd_head != '0) begin
            state_d  = ACTIVE;
            remain_d = cmd_head;
          end
        end
      end
      ACTIVE: begin
        if (out_valid) begin
          opnd_o      = bypass ? operand_i : data_mem[data_rd_q];
          opnd_strb_o = strb_calc;
          opnd_last_o = is_last;
        end
        if (hs) begin
          if (!is_last) begin
            remain_d = remain_q - WORD_BYTES;
          end else if (!cmd_empty && cmd_head != '0) begin
            // Chain straight into the next instruction so there is no bubble.
            cmd_pop  = 1'b1;
            remain_d = cmd_head;
          end else begin
            cmd_pop  = !cmd_empty;
            state_d  = IDLE;
            remain_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_operand_queue.sv
// Self-checking bench for operand_queue: table-driven framing vectors, directed corner cases
// and randomized traffic against a queue-based reference of the framing rules.
module tb_operand_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [15:0] cmd_vl_i;
  logic        op_valid_i, op_ready_o;
  logic [63:0] operand_i;
  logic        opnd_valid_o, opnd_ready_i;
  logic [63:0] opnd_o;
  logic [7:0]  opnd_strb_o;
  logic        opnd_last_o;
  logic [2:0]  occupancy_o;

  operand_queue dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_vl_i(cmd_vl_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .operand_i(operand_i),
    .opnd_valid_o(opnd_valid_o), .opnd_ready_i(opnd_ready_i), .opnd_o(opnd_o),
    .opnd_strb_o(opnd_strb_o), .opnd_last_o(opnd_last_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [15:0] cmd_q[$];
  logic [63:0] word_q[$];
  logic [63:0] exp_d[$];
  logic [7:0]  exp_s[$];
  logic        exp_l[$];
  logic [63:0] out_d[$];
  logic [7:0]  out_s[$];
  logic        out_l[$];
  int          out_c[$];

  int          occ_model;
  logic        stalled;
  logic [63:0] st_d;
  logic [7:0]  st_s;
  logic        st_l;
  logic        op_pushed, cmd_pushed;

  typedef struct {
    int         vl;
    int         nw;
    logic [7:0] last_strb;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_all();
    cmd_q.delete(); word_q.delete();
    exp_d.delete(); exp_s.delete(); exp_l.delete();
    out_d.delete(); out_s.delete(); out_l.delete(); out_c.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_vl_i = '0;
    op_valid_i = 1'b0; operand_i = '0; opnd_ready_i = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_op_ready", op_ready_o, 1);
    chk("rst_valid", opnd_valid_o, 0);
    chk("rst_last", opnd_last_o, 0);
    chk("rst_strb", opnd_strb_o, 0);
    chk("rst_data", opnd_o, 0);
    chk("rst_occ", occupancy_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    occ_model = 0;
    stalled = 1'b0;
    clear_all();
  endtask

  // Reference framing: each instruction of vl bytes yields ceil(vl/8) words.
  task automatic model_cmd(input int vl);
    int rem;
    rem = vl;
    while (rem > 0) begin
      exp_s.push_back((rem >= 8) ? 8'hFF : 8'((1 << rem) - 1));
      exp_l.push_back(rem <= 8);
      rem -= 8;
    end
  endtask

  task automatic gen_words(input int n);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      word_q.push_back(w);
      exp_d.push_back(w);
    end
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic cycle();
    logic hs;
    #1;
    chk("occupancy", occupancy_o, occ_model);
    chk("op_ready", op_ready_o, (occ_model < 4));
    if (!opnd_valid_o)
      chk("idle_outs_zero", (opnd_o != '0) || (opnd_strb_o != '0) || opnd_last_o, 0);
    if (stalled) begin
      chk("stall_valid", opnd_valid_o, 1);
      chk("stall_data", opnd_o, st_d);
      chk("stall_strb_last", {opnd_strb_o, opnd_last_o}, {st_s, st_l});
    end
    hs = opnd_valid_o && opnd_ready_i;
    op_pushed = op_valid_i && op_ready_o;
    cmd_pushed = cmd_valid_i && cmd_ready_o;
    if (hs) begin
      out_d.push_back(opnd_o);
      out_s.push_back(opnd_strb_o);
      out_l.push_back(opnd_last_o);
      out_c.push_back(cyc);
    end
    stalled = opnd_valid_o && !opnd_ready_i;
    st_d = opnd_o; st_s = opnd_strb_o; st_l = opnd_last_o;
    occ_model = occ_model + int'(op_pushed) - int'(hs);
    @(posedge clk_i); #1;
  endtask

  task automatic run(input int exp_n, input int rdy, input int vp, input int max_cyc);
    int k;
    int tail;
    int base;
    base = out_d.size(); k = 0; tail = 0;
    while (tail < 4 && k < max_cyc) begin
      cmd_valid_i  = (cmd_q.size() != 0) && ($urandom_range(99) < vp);
      cmd_vl_i     = (cmd_q.size() != 0) ? cmd_q[0] : '0;
      op_valid_i   = (word_q.size() != 0) && ($urandom_range(99) < vp);
      operand_i    = (word_q.size() != 0) ? word_q[0] : '0;
      opnd_ready_i = ($urandom_range(99) < rdy);
      cycle();
      if (cmd_pushed) void'(cmd_q.pop_front());
      if (op_pushed)  void'(word_q.pop_front());
      if (out_d.size() - base >= exp_n && cmd_q.size() == 0 && word_q.size() == 0) tail++;
      k++;
    end
    chk("run_done", (tail >= 4), 1);
    cmd_valid_i = 1'b0; op_valid_i = 1'b0; opnd_ready_i = 1'b0;
  endtask

  task automatic compare(input string name);
    int n;
    chk({name, "_count"}, out_d.size(), exp_d.size());
    n = (out_d.size() < exp_d.size()) ? out_d.size() : exp_d.size();
    if (exp_s.size() < n) n = exp_s.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_data"}, out_d[i], exp_d[i]);
      chk({name, "_strb"}, out_s[i], exp_s[i]);
      chk({name, "_last"}, out_l[i], exp_l[i]);
    end
    clear_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    int vl;
    logic [63:0] w;

    tbl[0] = '{vl: 20, nw: 3, last_strb: 8'h0F};
    tbl[1] = '{vl: 8,  nw: 1, last_strb: 8'hFF};
    tbl[2] = '{vl: 1,  nw: 1, last_strb: 8'h01};
    tbl[3] = '{vl: 17, nw: 3, last_strb: 8'h01};
    tbl[4] = '{vl: 32, nw: 4, last_strb: 8'hFF};
    tbl[5] = '{vl: 15, nw: 2, last_strb: 8'h7F};
    tbl[6] = '{vl: 30, nw: 4, last_strb: 8'h3F};

    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_vl_i = '0;
    op_valid_i = 1'b0; operand_i = '0; opnd_ready_i = 1'b0;
    occ_model = 0; stalled = 1'b0;
    @(posedge clk_i); #1;

    // Table-driven framing, then confirm the machine went back to IDLE.
    foreach (tbl[t]) begin
      do_reset();
      cmd_q.push_back(tbl[t].vl[15:0]);
      gen_words(tbl[t].nw);
      run(tbl[t].nw, 100, 100, 100);
      chk("tbl_count", out_d.size(), tbl[t].nw);
      for (int i = 0; i < out_d.size() && i < tbl[t].nw; i++) begin
        chk("tbl_data", out_d[i], exp_d[i]);
        chk("tbl_strb", out_s[i], (i == tbl[t].nw - 1) ? tbl[t].last_strb : 8'hFF);
        chk("tbl_last", out_l[i], (i == tbl[t].nw - 1));
      end
      clear_all();
      op_valid_i = 1'b1; operand_i = {$urandom, $urandom}; opnd_ready_i = 1'b1;
      cycle();
      op_valid_i = 1'b0;
      cycle(); cycle();
      chk("tbl_idle_after", opnd_valid_o, 0);
      opnd_ready_i = 1'b0;
    end

    // Words ahead of their command: FIFO fills to 4 and rejects the 5th.
    do_reset();
    gen_words(5);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      op_valid_i = 1'b1; operand_i = word_q[acc];
      cycle();
      if (op_pushed) acc++;
    end
    op_valid_i = 1'b0;
    chk("fill_accepted", acc, 4);
    chk("fill_op_ready", op_ready_o, 0);
    chk("fill_occ", occupancy_o, 4);
    chk("fill_no_output", opnd_valid_o, 0);
    word_q.delete();
    while (exp_d.size() > 4) void'(exp_d.pop_back());
    cmd_q.push_back(16'd32); model_cmd(32);
    run(4, 100, 100, 50);
    compare("fill");

    // Back-to-back instructions with no bubble.
    do_reset();
    cmd_q.push_back(16'd16); cmd_q.push_back(16'd8);
    model_cmd(16); model_cmd(8);
    gen_words(3);
    run(3, 100, 100, 50);
    if (out_c.size() >= 3) begin
      chk("b2b_gap1", out_c[1] - out_c[0], 1);
      chk("b2b_gap2", out_c[2] - out_c[1], 1);
    end
    compare("b2b");

    // Zero-length command is discarded.
    do_reset();
    cmd_q.push_back(16'd0); cmd_q.push_back(16'd8);
    model_cmd(0); model_cmd(8);
    gen_words(1);
    run(1, 100, 100, 50);
    compare("vl0");

    // Back-pressure hold for 5 cycles.
    do_reset();
    cmd_q.push_back(16'd16); model_cmd(16);
    gen_words(2);
    run(0, 0, 100, 50);
    chk("bp_valid", opnd_valid_o, 1);
    chk("bp_data_first", opnd_o, exp_d[0]);
    for (int i = 0; i < 5; i++) begin
      opnd_ready_i = 1'b0;
      cycle();
    end
    chk("bp_hold_data", opnd_o, exp_d[0]);
    chk("bp_hold_strb", opnd_strb_o, 8'hFF);
    chk("bp_hold_last", opnd_last_o, 0);
    run(2, 100, 100, 50);
    compare("bp");

    // Reset in the middle of an instruction.
    do_reset();
    cmd_q.push_back(16'd24);
    gen_words(3);
    run(0, 0, 100, 50);
    opnd_ready_i = 1'b1;
    cycle();
    opnd_ready_i = 1'b0;
    chk("mid_count", out_d.size(), 1);
    if (out_d.size() >= 1) chk("mid_data", out_d[0], exp_d[0]);
    do_reset();
    cmd_q.push_back(16'd8); model_cmd(8);
    gen_words(1);
    run(1, 100, 100, 50);
    compare("post_reset");

`ifdef OPQUEUE_BYPASS_EN
    // Zero-latency bypass of an empty FIFO.
    do_reset();
    cmd_q.push_back(16'd8);
    run(0, 0, 100, 20);
    chk("byp_pre_valid", opnd_valid_o, 0);
    w = {$urandom, $urandom};
    op_valid_i = 1'b1; operand_i = w; opnd_ready_i = 1'b1;
    #1;
    chk("byp_valid", opnd_valid_o, 1);
    chk("byp_data", opnd_o, w);
    chk("byp_occ", occupancy_o, 0);
    cycle();
    op_valid_i = 1'b0; opnd_ready_i = 1'b0;
    cycle();
    chk("byp_occ_after", occupancy_o, 0);
    chk("byp_out_count", out_d.size(), 1);
    clear_all();
`endif

    // Randomized traffic against the reference framing.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      n = 0;
      for (int c = 0; c < 30; c++) begin
        vl = $urandom_range(0, 40);
        cmd_q.push_back(vl[15:0]);
        model_cmd(vl);
        n += (vl + 7) / 8;
      end
      gen_words(n);
      run(n, (r == 0) ? 60 : 95, (r == 0) ? 70 : 40, 4000);
      compare("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_queue.md
# operand_queue

Per-lane, per-operand-type buffer sitting directly downstream of the VRF accesser's operand output. It absorbs VRF read words through a valid/ready handshake and frames them into per-instruction operand streams for the consuming VFU. Framing uses a per-instruction byte-length command, tail-byte strobes and a last flag. One instance exists per operand queue (ALUA, ALUB, StoreOp) per lane.

## Interface
- `Depth`, 4: data FIFO entries (≥2, power of two).
- `CmdDepth`, 2: command FIFO entries (≥1, power of two).
- `W` (derived, not a port): `VRFWordWidthB` bytes per word.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `cmd_valid_i`  in  1  instruction command valid, from the launcher.
- `cmd_ready_o`  out  1  command FIFO not full.
- `cmd_vl_i`  in  `lane_vlen_t`  bytes this lane reads for the instruction.
- `op_valid_i`  in  1  VRF operand word valid.
- `op_ready_o`  out  1  data FIFO can accept a word.
- `operand_i`  in  `vrf_data_t`  VRF operand word.
- `opnd_valid_o`  out  1  framed operand valid, to the VFU.
- `opnd_ready_i`  in  1  VFU accepts the operand.
- `opnd_o`  out  `vrf_data_t`  operand word.
- `opnd_strb_o`  out  `vrf_strb_t`  valid-byte mask.
- `opnd_last_o`  out  1  last word of the current instruction.
- `occupancy_o`  out  `$clog2(Depth)+1`  current data FIFO fill count.

## Operation
- Command FIFO: push on `cmd_valid_i && cmd_ready_o`.
- Data FIFO: push on `op_valid_i && op_ready_o`.
- `op_ready_o` = data FIFO not full. It never depends combinationally on `opnd_ready_i`, so a full FIFO rejects the word even in a cycle where it pops.
- Words may arrive before their command. They stay buffered until a command is active.
- State machine, with `remain_q` of type `lane_vlen_t`:
  - IDLE: if the command FIFO is non-empty, pop it, load `remain_q` from the head `cmd_vl_i` value, go to ACTIVE.
  - ACTIVE: `opnd_valid_o` = data FIFO non-empty (or bypass, see Configuration).
  - ACTIVE, on handshake `opnd_valid_o && opnd_ready_i`: pop the data word and set `remain_q -= W`.
  - ACTIVE, if `remain_q <= W` at that handshake: it is the last word. If the command FIFO is non-empty, reload `remain_q` from its head in the same cycle and stay ACTIVE. Otherwise go to IDLE.
- A command with `cmd_vl == 0` is popped and discarded in the cycle it is loaded: no output, and the machine stays or returns to IDLE.
- `opnd_strb_o` = all ones if `remain_q >= W`, else `(1<<remain_q)-1`.
- `opnd_last_o` = `remain_q <= W`.
- `opnd_o`, `opnd_strb_o` and `opnd_last_o` are meaningful only while `opnd_valid_o` is high; they are driven 0 otherwise.
- Once `opnd_valid_o` rises, it and the data outputs stay stable until the handshake.
- Data is never reordered or dropped.
- Reset, including mid-instruction: both FIFOs are emptied, `remain_q` = 0, state = IDLE.

## Timing
- Reset values:
  - `cmd_ready_o` = 1, `op_ready_o` = 1.
  - `opnd_valid_o` = 0, `opnd_last_o` = 0, `opnd_strb_o` = 0, `opnd_o` = 0.
  - `occupancy_o` = 0.
- Command accepted at cycle N: it is in the FIFO at N+1 and ACTIVE at N+2 if the machine was IDLE.
- Word accepted at cycle M: `opnd_valid_o` can be high at M+1 at the earliest (registered FIFO).
- Throughput is one word per cycle when full, including back-to-back instructions with no bubble on the last-to-first transition.
- Simultaneous push and pop when the FIFO is non-full and non-empty: occupancy is unchanged.

## Configuration
- `OPQUEUE_BYPASS_EN` defined: when ACTIVE, the data FIFO is empty and `op_valid_i` is high, `operand_i` drives `opnd_o` combinationally with `opnd_valid_o` = 1.
  - If `opnd_ready_i` is also high, the word is not written to the FIFO (0-cycle latency).
  - Otherwise it is pushed normally.
  - `op_ready_o` stays independent of `opnd_ready_i`.
- `OPQUEUE_BYPASS_EN` undefined: no bypass; minimum latency is 1 cycle.

## Test plan
Tests use `W` = 8.
- Reset, then command vl=20 and three words D0..D2 with `opnd_ready_i`=1: outputs D0 strb 0xFF last 0, D1 strb 0xFF last 0, D2 strb 0x0F last 1. The machine then returns to IDLE.
- 5 words pushed with no command and `Depth`=4: 4 accepted, `op_ready_o`=0, `occupancy_o`=4. Then command vl=32: four words out, the 4th with `last`=1.
- Two queued commands, vl=16 and vl=8, with 3 words and ready held high: outputs on 3 consecutive cycles, `last` on the 2nd and 3rd words, no bubble.
- Command vl=0 followed by command vl=8 and one word: exactly one output, strb 0xFF, last 1.
- Back-pressure: `opnd_ready_i`=0 for 5 cycles while valid: `opnd_o`, `opnd_strb_o` and `opnd_last_o` are stable, with no loss or duplication.
- `rst_i` pulsed mid-instruction after 1 of 3 words: all outputs return to reset values and `occupancy_o`=0. A following fresh command vl=8 with one word outputs normally.
- With `OPQUEUE_BYPASS_EN`: ACTIVE, FIFO empty, word and `opnd_ready_i` in the same cycle: `opnd_valid_o`=1 in that cycle and `occupancy_o` stays 0.
